// File: rtl/clk_sel_ctrl_pkg.sv
// Shared definitions for the clock-select sequencer: FSM state encoding,
// default timing parameters and a counter-width helper.
package clk_sel_ctrl_pkg;

   localparam int unsigned WIN_CYC_DEF    = 32;
   localparam int unsigned MIN_EDGES_DEF  = 2;
   localparam int unsigned SETTLE_CYC_DEF = 8;
   localparam int unsigned DWELL_CYC_DEF  = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_DWELL  = 2'd2
   } ctrl_state_e;

   // Bits needed to hold values 0..max_val (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/clk_sel_ctrl_activity_mon.sv
// Activity monitor for clk_in_1: synchronizer, rising-edge detector and a
// windowed saturating edge counter, all in the clk_in_0 domain.
module clk_activity_mon
   import clk_sel_ctrl_pkg::*;
#(
   parameter int unsigned WIN_CYC   = WIN_CYC_DEF,
   parameter int unsigned MIN_EDGES = MIN_EDGES_DEF
) (
   input  logic clk_in_0,
   input  logic rst_n_0,
   input  logic clk_in_1,
   output logic clk1_alive,
   output logic win_end,
   output logic win_alive
);

   localparam int unsigned WW = cnt_width(WIN_CYC - 1);
   localparam int unsigned EW = cnt_width(MIN_EDGES);
   localparam logic [WW-1:0] WIN_LAST = WW'(WIN_CYC - 1);
   localparam logic [EW-1:0] EDGE_SAT = EW'(MIN_EDGES);

   // [0],[1]: two-stage synchronizer; [2]: previous synchronized value.
   logic [2:0]    sync_q;
   logic          rise;
   logic [WW-1:0] win_q;
   logic [EW-1:0] edge_q;
   logic [EW-1:0] edge_total;

   assign rise = sync_q[1] & ~sync_q[2];

   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      edge_total = edge_q;
      if (rise && (edge_q != EDGE_SAT)) begin
         edge_total = edge_q + 1'b1;
      end
   end

   // The edge seen on the window's last cycle still counts toward its verdict.
   assign win_end   = (win_q == WIN_LAST);
   assign win_alive = (edge_total >= EDGE_SAT);

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk_in_0 or negedge rst_n_0) begin
      if (!rst_n_0) begin
         sync_q     <= '0;
         win_q      <= '0;
         edge_q     <= '0;
         clk1_alive <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], clk_in_1};
         if (win_end) begin
            win_q      <= '0;
            edge_q     <= '0;
            clk1_alive <= win_alive;
         end else begin
            win_q  <= win_q + 1'b1;
            edge_q <= edge_total;
         end
      end
   end

endmodule

// File: rtl/clk_sel_ctrl.sv
// Select sequencer for the glitch-free clock mux: request handshake, settle
// and dwell timing, and autonomous fallback to clk_in_0 when clk_in_1 dies.
module clk_sel_ctrl
   import clk_sel_ctrl_pkg::*;
#(
   parameter int unsigned WIN_CYC    = WIN_CYC_DEF,
   parameter int unsigned MIN_EDGES  = MIN_EDGES_DEF,
   parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
   parameter int unsigned DWELL_CYC  = DWELL_CYC_DEF
) (
   input  logic clk_in_0,
   input  logic rst_n_0,
   input  logic clk_in_1,
   input  logic req_valid,
   input  logic req_sel,
   output logic req_ready,
   output logic sel,
   output logic done,
   output logic err,
   output logic clk1_alive,
   output logic fallback
);

   localparam int unsigned CW =
      cnt_width((SETTLE_CYC > DWELL_CYC) ? SETTLE_CYC : DWELL_CYC);
   // Settle finishes on the SETTLE_CYC-th edge after the switch; dwell holds
   // one extra cycle so the block is ready again SETTLE+DWELL+1 after it.
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] DWELL_LOAD  = CW'(DWELL_CYC);

   ctrl_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sel_d, done_d, err_d, fallback_d;
   logic          win_end, win_alive;
   logic          fb_trig, accept;

   clk_activity_mon #(
      .WIN_CYC   (WIN_CYC),
      .MIN_EDGES (MIN_EDGES)
   ) u_mon (
      .clk_in_0   (clk_in_0),
      .rst_n_0    (rst_n_0),
      .clk_in_1   (clk_in_1),
      .clk1_alive (clk1_alive),
      .win_end    (win_end),
      .win_alive  (win_alive)
   );

   assign fb_trig = sel && win_end && !win_alive;
   // Ready drops while a fallback fires, so a request is never acknowledged and then dropped.
   assign req_ready = (state_q == ST_IDLE) && !fb_trig;
   assign accept    = req_valid && req_ready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sel_d      = sel;
      done_d     = 1'b0;
      err_d      = 1'b0;
      fallback_d = fallback;

      if (fb_trig) begin
         sel_d      = 1'b0;
         fallback_d = 1'b1;
         cnt_d      = SETTLE_LOAD;
         state_d    = ST_SETTLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  fallback_d = 1'b0;
                  if (req_sel == sel) begin
                     done_d = 1'b1;
                  end else if (req_sel && !clk1_alive) begin
                     err_d = 1'b1;
                  end else begin
                     sel_d   = req_sel;
                     cnt_d   = SETTLE_LOAD;
                     state_d = ST_SETTLE;
                  end
               end
            end
            ST_SETTLE: begin
               if (cnt_q == '0) begin
                  done_d  = 1'b1;
                  cnt_d   = DWELL_LOAD;
                  state_d = ST_DWELL;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_DWELL: begin
               if (cnt_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in_0 or negedge rst_n_0) begin
      if (!rst_n_0) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         sel      <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         fallback <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel      <= sel_d;
         done     <= done_d;
         err      <= err_d;
         fallback <= fallback_d;
      end
   end

endmodule
